// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: MMIO window, register offsets, reset values.
// Also holds the byte-lane merge helper used by every writable register.
package dmem_responder_pkg;

   localparam logic [15:0] DEF_MMIO_BASE = 16'hBFAF;

   localparam logic [15:0] LED_OFS  = 16'h0000;
   localparam logic [15:0] SEG_OFS  = 16'h0004;
   localparam logic [15:0] CNT_OFS  = 16'h0008;
   localparam logic [15:0] CMP_OFS  = 16'h000C;
   localparam logic [15:0] STAT_OFS = 16'h0010;

   localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

   // Replace only the byte lanes whose enable is set.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                               input logic [31:0] wdat,
                                               input logic [3:0]  be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = wdat[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/dmem_sram.sv
// Word-addressed data RAM with per-byte write enables.
// Latency: q is registered, one cycle after a read; q holds between reads. No backpressure.
module dmem_sram #(
   parameter int AW = 13
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] addr,
   input  logic          re,
   input  logic [3:0]    we,
   input  logic [31:0]   wdata,
   output logic [31:0]   q
);

   logic [31:0] mem [0:(1<<AW)-1];

   // Array has no reset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) q <= '0;
      else if (re) q <= mem[addr];
   end

endmodule

// File: rtl/dmem_responder.sv
// CPU data-memory slave: RAM plus LED/7-seg/timer MMIO registers.
// Latency: read data on dm one cycle after the access; dm holds until the next read.
// Backpressure: none, one access accepted every cycle.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int          RAM_AW    = 13,
   parameter logic [15:0] MMIO_BASE = DEF_MMIO_BASE
) (
   input  logic        cpu_clk_50M,
   input  logic        cpu_rst,
   input  logic [31:0] daddr,
   input  logic        dce,
   input  logic [3:0]  we,
   input  logic [31:0] din,
   output logic [31:0] dm,
   output logic [15:0] led,
   output logic [31:0] seg,
   output logic        timer_irq
);

   logic        mmio;
   logic [15:0] ofs;
   logic        acc_rd;
   logic        acc_wr;
   logic [3:0]  sram_we;
   logic [31:0] sram_q;

   logic [31:0] count_q;
   logic [31:0] compare_q;
   logic        status_q;
   logic        sel_mmio_q;
   logic [31:0] mmio_rdata;
   logic [31:0] mmio_rdata_q;

   logic        wr_led, wr_seg, wr_cnt, wr_cmp, wr_stat;
   logic [31:0] led_merged, seg_merged, cnt_merged, cmp_merged;

   assign mmio = (daddr[31:16] == MMIO_BASE);
   assign ofs  = daddr[15:0];

   // An access overlapping reset is dropped entirely.
   assign acc_rd  = dce && (we == 4'b0000) && !cpu_rst;
   assign acc_wr  = dce && (we != 4'b0000) && !cpu_rst;
   assign sram_we = (acc_wr && !mmio) ? we : 4'b0000;

   dmem_sram #(.AW(RAM_AW)) u_sram (
      .clk   (cpu_clk_50M),
      .rst   (cpu_rst),
      .addr  (daddr[RAM_AW+1:2]),
      .re    (acc_rd && !mmio),
      .we    (sram_we),
      .wdata (din),
      .q     (sram_q)
   );

   assign wr_led  = acc_wr && mmio && (ofs == LED_OFS);
   assign wr_seg  = acc_wr && mmio && (ofs == SEG_OFS);
   assign wr_cnt  = acc_wr && mmio && (ofs == CNT_OFS);
   assign wr_cmp  = acc_wr && mmio && (ofs == CMP_OFS);
   assign wr_stat = acc_wr && mmio && (ofs == STAT_OFS);

   assign led_merged = merge_bytes({16'h0000, led}, din, we);
   assign seg_merged = merge_bytes(seg, din, we);
   assign cnt_merged = merge_bytes(count_q, din, we);
   assign cmp_merged = merge_bytes(compare_q, din, we);

   always_comb begin
      mmio_rdata = '0;
      case (ofs)
         LED_OFS:  mmio_rdata = {16'h0000, led};
         SEG_OFS:  mmio_rdata = seg;
         CNT_OFS:  mmio_rdata = count_q;
         CMP_OFS:  mmio_rdata = compare_q;
         STAT_OFS: mmio_rdata = {31'h0, status_q};
         default:  mmio_rdata = '0;
      endcase
   end

   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         led          <= '0;
         seg          <= '0;
         count_q      <= '0;
         compare_q    <= CMP_RST;
         status_q     <= 1'b0;
         mmio_rdata_q <= '0;
         sel_mmio_q   <= 1'b0;
      end else begin
         if (wr_led) led <= led_merged[15:0];
         if (wr_seg) seg <= seg_merged;
         if (wr_cmp) compare_q <= cmp_merged;
         count_q <= wr_cnt ? cnt_merged : count_q + 32'd1;
         // Match uses pre-edge COUNT/COMPARE and beats a same-cycle W1C.
         if (count_q == compare_q) status_q <= 1'b1;
         else if (wr_stat && we[0] && din[0]) status_q <= 1'b0;
         if (acc_rd && mmio) mmio_rdata_q <= mmio_rdata;
         if (acc_rd) sel_mmio_q <= mmio;
      end
   end

   assign dm        = sel_mmio_q ? mmio_rdata_q : sram_q;
   assign timer_irq = status_q;

endmodule
